bf16_fpu_seq: RTL

Wishbone-slave controller that sequences the BFloat16 FPU core inside `user_proj_example`. It holds the operand and opcode registers, issues one operation at a time to the FPU, and captures the result and exception flags. It reports completion through a status register and `user_irq[0]`, with an optional watchdog timeout. The block sits between the Caravel Wishbone bus and the FPU datapath.

---
 rtl/bf16_fpu_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bf16_fpu_seq.sv
// Wishbone-slave sequencer for the BF16 FPU: operand/opcode registers, one-at-a-time issue, result/flag capture.
// Define FPU_SEQ_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYC cycles).
//
// state   | meaning
// S_IDLE  | no operation outstanding
// S_ISSUE | fpu_start_o high, operands presented on fpu_a_o/fpu_b_o/fpu_op_o
// S_WAIT  | waiting for fpu_done_i (or watchdog expiry)
module bf16_fpu_seq #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] fpu_a_o,
    output logic [15:0] fpu_b_o,
    output logic [2:0]  fpu_op_o,
    output logic        fpu_start_o,
    input  logic        fpu_done_i,
    input  logic [15:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t state_q, state_d;

    logic [15:0] opa_q, opb_q, result_q;
    logic [2:0]  op_q;
    logic        ie_q, done_q, ovr_q, tmo_q;
    logic [4:0]  flags_q;

    logic        hit, acc, wr, rd, busy;
    logic [5:0]  word;
    logic        start_req, issue, done_evt, tmo_evt, cmpl;
    logic        w1c_done, w1c_ovr, w1c_tmo, rd_res;
    logic [2:0]  op_nxt;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign word      = wbs_adr_i[7:2];
    assign acc       = wbs_ack_o & hit;
    assign wr        = acc & wbs_we_i;
    assign rd        = acc & ~wbs_we_i;
    assign busy      = (state_q != S_IDLE);
    assign start_req = wr & (word == 6'd2) & wbs_sel_i[1] & wbs_dat_i[8];
    assign issue     = start_req & ~busy;
    // the issuing CTRL write may also carry a new opcode
    assign op_nxt    = wbs_sel_i[0] ? wbs_dat_i[2:0] : op_q;
    assign done_evt  = (state_q == S_WAIT) & fpu_done_i;
    assign cmpl      = done_evt | tmo_evt;
    assign w1c_done  = wr & (word == 6'd3) & wbs_sel_i[0] & wbs_dat_i[1];
    assign w1c_ovr   = wr & (word == 6'd3) & wbs_sel_i[0] & wbs_dat_i[2];
    assign w1c_tmo   = wr & (word == 6'd3) & wbs_sel_i[0] & wbs_dat_i[3];
    assign rd_res    = rd & (word == 6'd4);

`ifdef FPU_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // down-counter loaded during ISSUE; expiry when it reaches zero in WAIT
    assign tmo_evt = (state_q == S_WAIT) & ~fpu_done_i & (tmo_cnt_q == 8'd0);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni)
            tmo_cnt_q <= 8'd0;
        else if (state_q == S_ISSUE)
            tmo_cnt_q <= 8'(TIMEOUT_CYC - 1);
        else if (state_q == S_WAIT && tmo_cnt_q != 8'd0)
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
    end

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};
`else
    assign tmo_evt     = 1'b0;
    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0], TIMEOUT_CYC[7:0]};
`endif

    always_comb begin
        state_d     = state_q;
        fpu_start_o = 1'b0;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_ISSUE;
            S_ISSUE: begin
                fpu_start_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT:  if (cmpl) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (word)
            6'd0: rd_data = {16'd0, opa_q};
            6'd1: rd_data = {16'd0, opb_q};
            6'd2: rd_data = {28'd0, ie_q, op_q};
            6'd3: rd_data = {23'd0, flags_q, tmo_q, ovr_q, done_q, busy};
            6'd4: rd_data = {16'd0, result_q};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= S_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            opa_q     <= 16'd0;
            opb_q     <= 16'd0;
            op_q      <= 3'd0;
            ie_q      <= 1'b0;
            fpu_a_o   <= 16'd0;
            fpu_b_o   <= 16'd0;
            fpu_op_o  <= 3'd0;
            result_q  <= 16'd0;
            flags_q   <= 5'd0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= hit & ~wbs_ack_o;
            wbs_dat_o <= (hit & ~wbs_ack_o & ~wbs_we_i) ? rd_data : 32'd0;
            irq_o     <= done_q & ie_q;

            if (wr && word == 6'd0) begin
                if (wbs_sel_i[0]) opa_q[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) opa_q[15:8] <= wbs_dat_i[15:8];
            end
            if (wr && word == 6'd1) begin
                if (wbs_sel_i[0]) opb_q[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) opb_q[15:8] <= wbs_dat_i[15:8];
            end
            if (wr && word == 6'd2 && wbs_sel_i[0]) begin
                op_q <= wbs_dat_i[2:0];
                ie_q <= wbs_dat_i[3];
            end

            if (issue) begin
                fpu_a_o  <= opa_q;
                fpu_b_o  <= opb_q;
                fpu_op_o <= op_nxt;
            end

            if (start_req && busy)
                ovr_q <= 1'b1;
            else if (w1c_ovr)
                ovr_q <= 1'b0;

            if (done_evt) begin
                result_q <= fpu_result_i;
                flags_q  <= fpu_flags_i;
            end else if (tmo_evt) begin
                result_q <= 16'h7FC0;
                flags_q  <= 5'b10000;
            end else if (issue) begin
                flags_q  <= 5'd0;
            end

            // completion beats any same-cycle clear
            if (cmpl)
                done_q <= 1'b1;
            else if (issue || w1c_done || rd_res)
                done_q <= 1'b0;

            if (tmo_evt)
                tmo_q <= 1'b1;
            else if (issue || w1c_tmo)
                tmo_q <= 1'b0;
        end
    end

endmodule
